instr_sequencer: RTL and testbench
==================================

Name: instr_sequencer

Overview:
Program sequencer for the single-cycle core `riscv_simple`. It holds a loadable instruction buffer and a program counter. While running, it drives one instruction per clock onto the core's `instr` input. It uses the core's `branch_taken` to choose the next PC, and halts on ECALL/EBREAK, on an external stop request, or on a fault. It sits between the system/bench (program load, start/stop) and the core.

Parameters:
DEPTH, 64, number of 32-bit instruction words in the buffer (power of 2, ≥4)
AW, $clog2(DEPTH), word-address width
CNT_W, 32, width of the retired-instruction counter

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  pulse; begin execution at PC 0 (accepted in IDLE or HALT)
stop  input  1  pulse; abort execution (accepted in RUN)
prog_we  input  1  buffer write enable (honoured only when not in RUN)
prog_addr  input  AW  buffer word address
prog_data  input  32  instruction word to write
instr  output  32  instruction to core; NOP (32'h00000013) unless in RUN
branch_taken  input  1  from core; combinational response to the current `instr`
pc  output  32  current byte PC; bits [1:0] always 0
running  output  1  high in RUN
done  output  1  high in HALT after a normal halt (ECALL/EBREAK/stop)
fault  output  1  high in HALT after a fault
retired  output  CNT_W  number of instructions issued in the current run

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, pc=0, done=0, fault=0, retired=0, instr=NOP.
  - Buffer contents are not cleared.
  - Reset mid-RUN aborts immediately; no partial update occurs.
- States:
  - IDLE: accepts prog_we; on start, goes to RUN with pc=0 and retired=0.
  - RUN: each cycle, instr = buf[pc[AW+1:2]] (combinational read).
  - HALT: holds pc, retired, done and fault; accepts prog_we; on start, goes to RUN with pc=0, retired=0, done=0, fault=0.
- RUN, per rising edge (priority top-down):
  1. stop=1: go to HALT, done=1, pc unchanged, retired unchanged (current instruction counted as not issued).
  2. instr==ECALL (32'h00000073) or EBREAK (32'h00100073): go to HALT, done=1, retired+=1, pc unchanged.
  3. Otherwise compute next = branch_taken ? pc + sext(B-imm of instr) : pc + 4, using 32-bit wrapping arithmetic.
     - B-imm = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}, sign-extended to 32 bits.
     - If next[1]==1 (misaligned) or next ≥ DEPTH*4 (unsigned; negative targets wrap and land here): go to HALT, fault=1, retired+=1, pc unchanged.
     - Else pc=next, retired+=1.
- branch_taken is sampled only in RUN and only on a non-halting instruction; it is ignored otherwise.
- Latency: first instruction appears on instr in the cycle after start is sampled. Throughput is one instruction per cycle.
- retired saturates at all-ones and does not wrap.
- Simultaneous events:
  - start+stop in RUN: stop wins, start is ignored.
  - start in RUN alone: ignored.
  - prog_we in RUN: ignored; the buffer is unchanged.
  - prog_we and start in the same cycle from IDLE/HALT: the write completes, and the new word is visible to the first fetch.
- Buffer: synchronous write, asynchronous read; prog_addr is a word index.
- A taken branch with offset 0 loops indefinitely; only stop or reset exits.

Decomposition:
- defines.v gains:
  - `NOP_INSTR`, `ECALL_INSTR`, `EBREAK_INSTR`
  - `SEQ_IDLE`/`SEQ_RUN`/`SEQ_HALT` 2-bit encodings
  - `OPC_BRANCH` (7'b1100011), for bench checks
- One sub-module, instr_buffer: DEPTH×32 register array with a sync write port and an async read port.
- B-imm extraction and next-PC/fault logic stay inline in instr_sequencer.

Test Plan:
1. Load [00500093, 00A00113, 002081B3, 00000073]; start. Required:
   - running goes high for 4 cycles; core aluresult=15 on the third.
   - Then done=1, fault=0, pc=12, retired=4, instr=NOP.
2. Load [00500093, 00500113, 00208463 (beq x1,x2,+8), 00000013, 00000073]; start. Required: pc sequence 0,4,8,16; done=1, retired=4, word 3 never issued.
3. Load [00500093, 00208063 (beq x1,x2,0; not taken since x2=0), 00000073]. Required: retired=3, done=1. Then change word 0 to 00000113 (x2=0=x1) and start again. Required: pc sticks at 4 (taken); assert stop after 10 cycles → done=1, fault=0, pc=4.
4. Fault: DEPTH=64, single word FE000EE3 (beq x0,x0,-4 from pc 0). Required: fault=1, done=0, pc=0, retired=1. Also run 63 NOPs plus a NOP at word 63. Required: fault=1 at pc=252.
5. Reset mid-RUN (rst_n low for 3ns between edges during test 3's loop). Required: immediately state=IDLE, pc=0, retired=0, instr=NOP. Buffer intact: a restart reproduces test 3's result.
6. Corner cases:
   - prog_we during RUN: the buffer word is unchanged after halt.
   - start+stop together in RUN: HALT with done=1.
   - prog_we at word 0 together with start: the first fetched instr equals the new data.

Source files
------------

// File: rtl/instr_sequencer_pkg.sv
// Shared constants and state encoding for the instruction sequencer.
package instr_sequencer_pkg;

  localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
  localparam logic [31:0] ECALL_INSTR  = 32'h0000_0073;
  localparam logic [31:0] EBREAK_INSTR = 32'h0010_0073;
  localparam logic [6:0]  OPC_BRANCH   = 7'b1100011;

  typedef enum logic [1:0] {
    SEQ_IDLE = 2'd0,
    SEQ_RUN  = 2'd1,
    SEQ_HALT = 2'd2
  } seq_state_t;

endpackage

// File: rtl/instr_sequencer_buffer.sv
// Instruction store: DEPTH x 32 registers, synchronous write, asynchronous read.
// Contents are deliberately not reset so a program survives a sequencer reset.
module instr_buffer #(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/instr_sequencer.sv
// Program sequencer for riscv_simple: issues one buffered instruction per cycle,
// follows the core's branch decision and halts on ECALL/EBREAK, stop or fault.
module instr_sequencer
  import instr_sequencer_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH),
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             prog_we,
  input  logic [AW-1:0]    prog_addr,
  input  logic [31:0]      prog_data,
  output logic [31:0]      instr,
  input  logic             branch_taken,
  output logic [31:0]      pc,
  output logic             running,
  output logic             done,
  output logic             fault,
  output logic [CNT_W-1:0] retired
);

  localparam logic [31:0] PC_LIMIT = 32'(DEPTH * 4);

  seq_state_t       state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [CNT_W-1:0] ret_q, ret_d, ret_inc;
  logic             done_q, done_d, fault_q, fault_d;
  logic [31:0]      fetch_word, imm_b, next_pc;
  logic             is_sys, bad_target;

  instr_buffer #(.DEPTH(DEPTH), .AW(AW)) u_buf (
    .clk   (clk),
    .we    (prog_we && (state_q != SEQ_RUN)),
    .waddr (prog_addr),
    .wdata (prog_data),
    .raddr (pc_q[AW+1:2]),
    .rdata (fetch_word)
  );

  // Negative targets wrap to huge unsigned values and so fail the limit test too.
  assign imm_b      = {{19{fetch_word[31]}}, fetch_word[31], fetch_word[7],
                       fetch_word[30:25], fetch_word[11:8], 1'b0};
  assign next_pc    = branch_taken ? (pc_q + imm_b) : (pc_q + 32'd4);
  assign bad_target = next_pc[1] || (next_pc >= PC_LIMIT);
  assign is_sys     = (fetch_word == ECALL_INSTR) || (fetch_word == EBREAK_INSTR);
  assign ret_inc    = (&ret_q) ? ret_q : (ret_q + CNT_W'(1));

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ret_d   = ret_q;
    done_d  = done_q;
    fault_d = fault_q;
    case (state_q)
      SEQ_IDLE, SEQ_HALT: begin
        if (start) begin
          state_d = SEQ_RUN;
          pc_d    = '0;
          ret_d   = '0;
          done_d  = 1'b0;
          fault_d = 1'b0;
        end
      end
      SEQ_RUN: begin
        if (stop) begin
          state_d = SEQ_HALT;
          done_d  = 1'b1;
        end else if (is_sys) begin
          state_d = SEQ_HALT;
          done_d  = 1'b1;
          ret_d   = ret_inc;
        end else if (bad_target) begin
          state_d = SEQ_HALT;
          fault_d = 1'b1;
          ret_d   = ret_inc;
        end else begin
          pc_d  = next_pc;
          ret_d = ret_inc;
        end
      end
      default: state_d = SEQ_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SEQ_IDLE;
      pc_q    <= '0;
      ret_q   <= '0;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ret_q   <= ret_d;
      done_q  <= done_d;
      fault_q <= fault_d;
    end
  end

  assign running = (state_q == SEQ_RUN);
  assign instr   = running ? fetch_word : NOP_INSTR;
  assign pc      = pc_q;
  assign done    = done_q;
  assign fault   = fault_q;
  assign retired = ret_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: a tiny core model drives branch_taken for the directed
// programs, then random programs run with random branch decisions against a program model.
module tb_instr_sequencer;
  import instr_sequencer_pkg::*;

  localparam int DEPTH = 64;
  localparam int AW    = 6;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic             prog_we = 1'b0;
  logic [AW-1:0]    prog_addr = '0;
  logic [31:0]      prog_data = '0;
  logic [31:0]      instr, pc;
  logic             branch_taken, running, done, fault;
  logic [CNT_W-1:0] retired;

  int n_checks = 0;
  int n_fail   = 0;

  logic        core_mode = 1'b1;
  logic        rand_bt = 1'b0;
  logic        core_taken;
  logic [31:0] xreg [32];
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] i_imm;

  logic [31:0] m_mem [DEPTH];
  bit          m_run, m_done, m_fault;
  longint      m_pc, m_ret;
  longint      pc_trace[$];

  always #5 clk = ~clk;

  instr_sequencer #(.DEPTH(DEPTH), .AW(AW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .instr(instr), .branch_taken(branch_taken), .pc(pc), .running(running),
    .done(done), .fault(fault), .retired(retired)
  );

  // Minimal core: ADDI/ADD write registers, BEQ decides branch_taken.
  assign rd    = instr[11:7];
  assign rs1   = instr[19:15];
  assign rs2   = instr[24:20];
  assign i_imm = {{20{instr[31]}}, instr[31:20]};
  assign core_taken = (instr[6:0] == OPC_BRANCH) && (instr[14:12] == 3'b000) &&
                      (xreg[rs1] == xreg[rs2]);
  assign branch_taken = core_mode ? core_taken : rand_bt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) xreg[i] <= '0;
    end else if (start && !running) begin
      for (int i = 0; i < 32; i++) xreg[i] <= '0;
    end else if (running && !stop && rd != 5'd0) begin
      if (instr[6:0] == 7'b0010011 && instr[14:12] == 3'b000)
        xreg[rd] <= xreg[rs1] + i_imm;
      else if (instr[6:0] == 7'b0110011 && instr[14:12] == 3'b000 && instr[31:25] == 7'd0)
        xreg[rd] <= xreg[rs1] + xreg[rs2];
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s: actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_done = 0; m_fault = 0; m_pc = 0; m_ret = 0;
  endtask

  // Program-level view: which word executes, where control goes, when the run ends.
  task automatic model_step();
    bit          was_run;
    logic [31:0] cur;
    int          imm;
    longint      target;
    was_run = m_run;
    if (m_run) begin
      cur = m_mem[int'(m_pc / 4)];
      if (stop) begin
        m_run = 0; m_done = 1;
      end else begin
        if (m_ret < (longint'(1) << CNT_W) - 1) m_ret++;
        if (cur == ECALL_INSTR || cur == EBREAK_INSTR) begin
          m_run = 0; m_done = 1;
        end else begin
          imm = int'({cur[31], cur[7], cur[30:25], cur[11:8], 1'b0});
          if (imm >= 4096) imm -= 8192;
          target = branch_taken ? m_pc + longint'(imm) : m_pc + 4;
          if (target < 0 || target >= DEPTH * 4 || target % 4 != 0) begin
            m_run = 0; m_fault = 1;
          end else begin
            m_pc = target;
          end
        end
      end
    end else if (start) begin
      m_run = 1; m_pc = 0; m_ret = 0; m_done = 0; m_fault = 0;
    end
    if (prog_we && !was_run) m_mem[prog_addr] = prog_data;
  endtask

  task automatic compare();
    logic [31:0] exp_instr;
    exp_instr = m_run ? m_mem[int'(m_pc / 4)] : NOP_INSTR;
    checkOutput("running", 32'(running), 32'(m_run));
    checkOutput("done", 32'(done), 32'(m_done));
    checkOutput("fault", 32'(fault), 32'(m_fault));
    checkOutput("pc", pc, 32'(m_pc));
    checkOutput("retired", 32'(retired), 32'(m_ret));
    checkOutput("instr", instr, exp_instr);
    if (running) pc_trace.push_back(longint'(pc));
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step();
    @(negedge clk);
    if (rst_n) compare();
  endtask

  task automatic write_word(input int a, input logic [31:0] d);
    prog_we = 1'b1; prog_addr = AW'(a); prog_data = d;
    tick();
    prog_we = 1'b0;
  endtask

  task automatic applyStimulus(input logic with_stop);
    start = 1'b1; stop = with_stop;
    tick();
    start = 1'b0; stop = 1'b0;
  endtask

  task automatic stop_pulse();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic wait_halt(input int budget, output int cycles);
    cycles = 0;
    while (running && cycles < budget) begin
      cycles++;
      tick();
    end
    n_checks++;
    if (running) begin
      n_fail++;
      $display("[TB] FAIL halt_timeout: still running after %0d cycles", budget);
    end
  endtask

  function automatic logic [31:0] enc_beq(input int off);
    logic [12:0] b;
    b = 13'(off);
    return {b[12], b[10:5], 5'd2, 5'd1, 3'b000, b[4:1], b[11], OPC_BRANCH};
  endfunction

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    case ($urandom_range(0, 9))
      0, 1:    w = NOP_INSTR;
      2, 3:    w = {12'($urandom), 5'($urandom), 3'b000, 5'($urandom), 7'b0010011};
      4, 5, 6: w = enc_beq((int'($urandom_range(0, 40)) - 20) * 2);
      7:       w = $urandom_range(0, 1) ? ECALL_INSTR : EBREAK_INSTR;
      8:       w = $urandom;
      default: w = enc_beq(0);
    endcase
    return w;
  endfunction

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cyc;
    int t0;
    int r;
    int exp_pcs[4];
    exp_pcs = '{0, 4, 8, 16};
    model_reset();
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    checkOutput("reset_pc", pc, 32'd0);
    checkOutput("reset_running", 32'(running), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_retired", 32'(retired), 32'd0);
    checkOutput("reset_instr", instr, NOP_INSTR);
    for (int i = 0; i < DEPTH; i++) write_word(i, NOP_INSTR);

    $display("[TB] straight-line program");
    write_word(0, 32'h0050_0093); write_word(1, 32'h00A0_0113);
    write_word(2, 32'h0020_81B3); write_word(3, ECALL_INSTR);
    applyStimulus(1'b0);
    wait_halt(20, cyc);
    checkOutput("t1_run_cycles", 32'(cyc), 32'd4);
    checkOutput("t1_done", 32'(done), 32'd1);
    checkOutput("t1_fault", 32'(fault), 32'd0);
    checkOutput("t1_pc", pc, 32'd12);
    checkOutput("t1_retired", 32'(retired), 32'd4);
    checkOutput("t1_instr", instr, NOP_INSTR);
    checkOutput("t1_x3", xreg[3], 32'd15);

    $display("[TB] taken branch skips a word");
    write_word(0, 32'h0050_0093); write_word(1, 32'h0050_0113);
    write_word(2, 32'h0020_8463); write_word(3, NOP_INSTR); write_word(4, ECALL_INSTR);
    t0 = pc_trace.size();
    applyStimulus(1'b0);
    wait_halt(20, cyc);
    checkOutput("t2_trace_len", 32'(pc_trace.size() - t0), 32'd4);
    for (int i = 0; i < 4 && t0 + i < pc_trace.size(); i++)
      checkOutput("t2_pc_seq", 32'(pc_trace[t0 + i]), 32'(exp_pcs[i]));
    checkOutput("t2_retired", 32'(retired), 32'd4);
    checkOutput("t2_done", 32'(done), 32'd1);

    $display("[TB] untaken then self-loop");
    rst_n = 1'b0; model_reset(); #3 rst_n = 1'b1;
    write_word(0, 32'h0050_0093); write_word(1, 32'h0020_8063); write_word(2, ECALL_INSTR);
    applyStimulus(1'b0);
    wait_halt(20, cyc);
    checkOutput("t3_retired", 32'(retired), 32'd3);
    checkOutput("t3_done", 32'(done), 32'd1);
    write_word(0, 32'h0000_0113);
    applyStimulus(1'b0);
    repeat (10) tick();
    checkOutput("t3_loop_pc", pc, 32'd4);
    stop_pulse();
    checkOutput("t3_stop_done", 32'(done), 32'd1);
    checkOutput("t3_stop_fault", 32'(fault), 32'd0);
    checkOutput("t3_stop_pc", pc, 32'd4);

    $display("[TB] reset in the middle of a run");
    applyStimulus(1'b0);
    repeat (5) tick();
    @(posedge clk);
    model_step();
    #1 rst_n = 1'b0; model_reset();
    #1;
    checkOutput("t5_rst_running", 32'(running), 32'd0);
    checkOutput("t5_rst_pc", pc, 32'd0);
    checkOutput("t5_rst_retired", 32'(retired), 32'd0);
    checkOutput("t5_rst_instr", instr, NOP_INSTR);
    #2 rst_n = 1'b1;
    @(negedge clk);
    compare();
    applyStimulus(1'b0);
    repeat (300) tick();
    stop_pulse();
    checkOutput("t5_done", 32'(done), 32'd1);
    checkOutput("t5_pc", pc, 32'd4);
    checkOutput("t5_retired_sat", 32'(retired), 32'd255);

    $display("[TB] corner cases");
    applyStimulus(1'b0);
    repeat (3) tick();
    write_word(1, ECALL_INSTR);
    repeat (3) tick();
    checkOutput("t6_we_in_run", 32'(running), 32'd1);
    stop_pulse();
    applyStimulus(1'b0);
    repeat (5) tick();
    checkOutput("t6_buf_kept_pc", pc, 32'd4);
    checkOutput("t6_buf_kept_run", 32'(running), 32'd1);
    applyStimulus(1'b1);
    checkOutput("t6_startstop_done", 32'(done), 32'd1);
    checkOutput("t6_startstop_run", 32'(running), 32'd0);
    prog_we = 1'b1; prog_addr = '0; prog_data = ECALL_INSTR; start = 1'b1;
    tick();
    prog_we = 1'b0; start = 1'b0;
    checkOutput("t6_we_start_instr", instr, ECALL_INSTR);
    wait_halt(10, cyc);
    checkOutput("t6_we_start_retired", 32'(retired), 32'd1);

    $display("[TB] fault cases");
    write_word(0, 32'hFE00_0EE3);
    applyStimulus(1'b0);
    wait_halt(10, cyc);
    checkOutput("t4_fault", 32'(fault), 32'd1);
    checkOutput("t4_done", 32'(done), 32'd0);
    checkOutput("t4_pc", pc, 32'd0);
    checkOutput("t4_retired", 32'(retired), 32'd1);
    for (int i = 0; i < DEPTH; i++) write_word(i, NOP_INSTR);
    applyStimulus(1'b0);
    wait_halt(100, cyc);
    checkOutput("t4_end_fault", 32'(fault), 32'd1);
    checkOutput("t4_end_pc", pc, 32'd252);
    checkOutput("t4_end_retired", 32'(retired), 32'd64);

    $display("[TB] random programs");
    core_mode = 1'b0;
    for (int it = 0; it < 40; it++) begin
      for (int w = 0; w < 16; w++) write_word(w, rand_word());
      applyStimulus(1'b0);
      cyc = 0;
      while (running && cyc < 120) begin
        rand_bt = 1'($urandom);
        r = int'($urandom_range(0, 59));
        if (r == 0) stop = 1'b1;
        if (r >= 1 && r <= 6) begin
          prog_we = 1'b1; prog_addr = AW'($urandom); prog_data = $urandom;
        end
        if (r == 7) start = 1'b1;
        tick();
        stop = 1'b0; prog_we = 1'b0; start = 1'b0;
        cyc++;
      end
      if (running) stop_pulse();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
